// File: rtl/demux_4x_nbit_stream.sv
// 1-to-4 stream demultiplexer with a one-entry valid/ready register per output channel.
// Optional DEMUX_DROP_EN: never backpressure; beats to a stalled full channel are dropped and counted.
module demux_4x_nbit_stream #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] out_a,
    output logic [BUS_WIDTH-1:0] out_b,
    output logic [BUS_WIDTH-1:0] out_c,
    output logic [BUS_WIDTH-1:0] out_d,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t               r_state [4];
    logic [BUS_WIDTH-1:0] r_data  [4];

    logic [3:0] w_room;
    logic [3:0] w_drain;
    logic [3:0] w_load;

    // A channel has room when it is empty or is handing its beat off this cycle.
    always_comb begin
        w_room  = '0;
        w_drain = '0;
        w_load  = '0;
        for (int k = 0; k < 4; k++) begin
            w_room[k]  = !out_valid[k] || out_ready[k];
            w_drain[k] = out_valid[k] && out_ready[k];
        end
        if (in_valid && w_room[in_sel]) begin
            w_load[in_sel] = 1'b1;
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (r_state[k] == S_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= S_EMPTY;
                r_data[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (r_state[k])
                    S_EMPTY: if (w_load[k]) r_state[k] <= S_FULL;
                    S_FULL:  if (w_drain[k] && !w_load[k]) r_state[k] <= S_EMPTY;
                    default: r_state[k] <= S_EMPTY;
                endcase
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    assign out_a = r_data[0];
    assign out_b = r_data[1];
    assign out_c = r_data[2];
    assign out_d = r_data[3];

`ifdef DEMUX_DROP_EN
    logic                 w_drop;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    assign w_drop = in_valid && !w_room[in_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign in_ready = 1'b1;
    assign drop_cnt = r_drop_cnt;
`else
    assign in_ready = w_room[in_sel];
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_4x_nbit_stream.sv
// Bench for demux_4x_nbit_stream: directed vector table, hand sequences and random traffic vs a queue-style model.
// Honours DEMUX_DROP_EN when defined for the build.
module tb_demux_4x_nbit_stream;

    localparam int BW = 8;
    localparam int CW = 8;
`ifdef DEMUX_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out_a, out_b, out_c, out_d;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [CW-1:0] drop_cnt;

    demux_4x_nbit_stream #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] rd);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rd;
        #1;
    endtask

    // Reference model: each channel is a holding slot plus a "occupied" flag.
    logic       mv [4];
    logic [7:0] md [4];
    int         mdrop;

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = 8'h00; end
        mdrop = 0;
    endtask

    task automatic run_cycle(input string tag, input logic r, input logic v,
                             input logic [1:0] s, input logic [7:0] d, input logic [3:0] rd);
        logic room;
        drive(r, v, s, d, rd);
        room = !mv[s] || rd[s];
        check({tag, "_in_ready"}, in_ready, room || DROP);
        @(posedge clk); #1;
        if (r) begin
            model_clear();
        end else begin
            for (int k = 0; k < 4; k++) if (mv[k] && rd[k]) mv[k] = 1'b0;
            if (v && room) begin
                mv[s] = 1'b1;
                md[s] = d;
            end else if (v && DROP && mdrop < (2**CW - 1)) begin
                mdrop++;
            end
        end
        check({tag, "_valid"}, out_valid, {mv[3], mv[2], mv[1], mv[0]});
        check({tag, "_out"}, {out_d, out_c, out_b, out_a}, {md[3], md[2], md[1], md[0]});
        check({tag, "_drop"}, drop_cnt, mdrop);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] rd;
        logic       chk;
        logic       ex_rdy;
        logic [3:0] ex_v;
        logic [7:0] ea, eb, ec, ed;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // reset with in_valid high
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00};
        // routing
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 1'b1, 4'h1, 8'h11, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 1'b1, 4'h2, 8'h11, 8'h22, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 1'b1, 4'h4, 8'h11, 8'h22, 8'h33, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 1'b1, 4'h8, 8'h11, 8'h22, 8'h33, 8'h44};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'hEE, 4'hF, 1'b1, 1'b1, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44};
        // stall on channel c, then drain + load in one cycle
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'hB, 1'b1, 1'b1, 4'h4, 8'h11, 8'h22, 8'hA5, 8'h44};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 8'h5A, 4'hB, 1'b1, 1'b0, 4'h4, 8'h11, 8'h22, 8'hA5, 8'h44};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 8'h5A, 4'hF, 1'b1, 1'b1, 4'h4, 8'h11, 8'h22, 8'h5A, 8'h44};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'hF, 1'b1, 1'b1, 4'h0, 8'h11, 8'h22, 8'h5A, 8'h44};
        // independence: b stalled and full, d still flows
        tbl[11] = '{1'b0, 1'b1, 2'd1, 8'hBB, 4'hD, 1'b1, 1'b1, 4'h2, 8'h11, 8'hBB, 8'h5A, 8'h44};
        tbl[12] = '{1'b0, 1'b1, 2'd3, 8'h77, 4'hD, 1'b1, 1'b1, 4'hA, 8'h11, 8'hBB, 8'h5A, 8'h77};
        tbl[13] = '{1'b0, 1'b1, 2'd1, 8'hCC, 4'hD, 1'b1, 1'b0, 4'h2, 8'h11, 8'hBB, 8'h5A, 8'h77};
        // fill a and c, then reset with every consumer ready
        tbl[14] = '{1'b0, 1'b1, 2'd0, 8'h12, 4'h0, 1'b1, 1'b1, 4'h3, 8'h12, 8'hBB, 8'h5A, 8'h77};
        tbl[15] = '{1'b0, 1'b1, 2'd2, 8'h34, 4'h0, 1'b1, 1'b1, 4'h7, 8'h12, 8'hBB, 8'h34, 8'h77};
        tbl[16] = '{1'b1, 1'b1, 2'd1, 8'hFF, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00};

        drive(1'b1, 1'b1, 2'd0, 8'hFF, 4'hF);
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].rd);
            if (tbl[i].chk) check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ex_rdy || DROP);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ex_v);
            check($sformatf("tbl%0d_out", i), {out_d, out_c, out_b, out_a},
                  {tbl[i].ed, tbl[i].ec, tbl[i].eb, tbl[i].ea});
`ifndef DEMUX_DROP_EN
            check($sformatf("tbl%0d_drop", i), drop_cnt, 0);
`endif
        end

        // table ended in reset: model starts empty
        model_clear();

        // back-to-back drain+load on one channel
        for (int i = 0; i < 5; i++) run_cycle("thru", 1'b0, 1'b1, 2'd0, 8'h80 + 8'(i), 4'h1);
        // stall channel a, beats to a refused/dropped, others still move
        run_cycle("stall0", 1'b0, 1'b1, 2'd0, 8'h90, 4'h0);
        run_cycle("stall1", 1'b0, 1'b1, 2'd0, 8'h91, 4'h0);
        run_cycle("stall2", 1'b0, 1'b1, 2'd3, 8'h92, 4'h0);
        run_cycle("stall3", 1'b0, 1'b1, 2'd0, 8'h93, 4'h0);
        run_cycle("rel", 1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

`ifdef DEMUX_DROP_EN
        run_cycle("drst", 1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        run_cycle("dfill", 1'b0, 1'b1, 2'd0, 8'h3C, 4'h0);
        for (int i = 0; i < 3; i++) run_cycle("ddrop", 1'b0, 1'b1, 2'd0, 8'hC0 + 8'(i), 4'h0);
        check("drop3_cnt", drop_cnt, 3);
        check("drop3_out_a", out_a, 8'h3C);
        for (int i = 0; i < 300; i++) run_cycle("dsat", 1'b0, 1'b1, 2'd0, 8'(i), 4'h0);
        check("drop_sat", drop_cnt, 2**CW - 1);
        run_cycle("drst2", 1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] rd;
            r  = ($urandom_range(0, 99) == 0);
            rd = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rd = 4'hF;
            run_cycle("rnd", r, 1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
